seg_display_ctrl: RTL

Parametrised binary-to-seven-segment display controller for the FPGA top level, sitting between a result-producing accelerator (such as the factorial datapath) and the board's multiplexed 7-segment display. It accepts a binary value through a load handshake and converts it to BCD with a sequential double-dabble engine. It then scans the decimal digits onto a common-anode display at a configurable refresh rate. The previously converted value stays on the display while a new conversion runs.

---
 rtl/seg_pkg.sv | 46 ++++
 rtl/bin2bcd_seq.sv | 89 ++++++++
 rtl/seg_display_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display controller: active-low
// segment codes, converter FSM states and the BCD sizing helper.
package seg_pkg;

    // Segment order {dp,g,f,e,d,c,b,a}, active-low; dp is always off.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    // floor(width*log10(2))+1: decimal digits of 2**width-1 (10 for 32 bits).
    function automatic int bcd_digits(input int width);
        return (width * 30103) / 100000 + 1;
    endfunction

    function automatic logic [7:0] seg_encode(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one binary bit per cycle, MSB first,
// followed by a single COMMIT cycle flagged on done.
//
// state     | meaning
// ST_IDLE   | waiting for load; accepts value and clears the BCD register
// ST_SHIFT  | one add-3/shift iteration per cycle, DATA_W cycles
// ST_COMMIT | bcd holds the final result; done pulses for one cycle
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int BCD_DIGITS = seg_pkg::bcd_digits(DATA_W)
) (
    input  logic                    clk100MHz,
    input  logic                    rst,
    input  logic                    load,
    input  logic [DATA_W-1:0]       value,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    conv_state_t             state_q, state_d;
    logic [DATA_W-1:0]       bin_q;
    logic [4*BCD_DIGITS-1:0] bcd_q, bcd_adj;
    logic [CNT_W-1:0]        bit_cnt;

    always_ff @(posedge clk100MHz or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (bit_cnt == '0) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // bit_cnt is a down-counter of remaining iterations; zero marks the last one.
    always_ff @(posedge clk100MHz or negedge rst) begin
        if (!rst) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        bin_q   <= value;
                        bcd_q   <= '0;
                        bit_cnt <= CNT_W'(DATA_W - 1);
                    end
                end
                ST_SHIFT: begin
                    {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                    bit_cnt        <= bit_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bcd = bcd_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// Binary-to-seven-segment controller: converts a loaded value to BCD and scans
// it onto a multiplexed common-anode display. Optional LEADING_ZERO_BLANK_EN.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_DIGITS = 8,
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 5000
) (
    input  logic                  clk100MHz,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_W-1:0]     value,
    output logic                  busy,
    output logic                  overflow,
    output logic [7:0]            LEDOUT,
    output logic [NUM_DIGITS-1:0] LEDSEL
);

    localparam int TICK_DIV   = CLK_HZ / REFRESH_HZ;
    localparam int TICK_W     = $clog2(TICK_DIV);
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BCD_DIGITS = bcd_digits(DATA_W);
    localparam int EXT_DIGITS = (NUM_DIGITS > BCD_DIGITS) ? NUM_DIGITS : BCD_DIGITS;

    logic [4*BCD_DIGITS-1:0]     bcd;
    logic [4*EXT_DIGITS-1:0]     bcd_ext;
    logic                        conv_done;
    logic [NUM_DIGITS-1:0][3:0]  disp_digits, disp_next;
    logic                        ovf_next;
    logic [NUM_DIGITS-1:0]       digit_blank;
    logic [TICK_W-1:0]           tick_cnt;
    logic [IDX_W-1:0]            scan_idx;
    logic [7:0]                  seg_next;
    logic [NUM_DIGITS-1:0]       sel_next;

    bin2bcd_seq #(
        .DATA_W    (DATA_W),
        .BCD_DIGITS(BCD_DIGITS)
    ) u_conv (
        .clk100MHz(clk100MHz),
        .rst      (rst),
        .load     (load),
        .value    (value),
        .busy     (busy),
        .done     (conv_done),
        .bcd      (bcd)
    );

    // Zero-extend so a display wider than the converter simply shows zeros.
    assign bcd_ext = (4*EXT_DIGITS)'(bcd);

    always_comb begin
        disp_next = '0;
        ovf_next  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) disp_next[i] = bcd_ext[4*i +: 4];
        for (int i = NUM_DIGITS; i < EXT_DIGITS; i++) begin
            if (bcd_ext[4*i +: 4] != 4'd0) ovf_next = 1'b1;
        end
    end

    // Only the COMMIT cycle writes the display, so scanning never sees a partial result.
    always_ff @(posedge clk100MHz or negedge rst) begin
        if (!rst) begin
            disp_digits <= '0;
            overflow    <= 1'b0;
        end else if (conv_done) begin
            disp_digits <= disp_next;
            overflow    <= ovf_next;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic upper_zero;

    always_comb begin
        upper_zero  = 1'b1;
        digit_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero     = upper_zero & (disp_digits[i] == 4'd0);
            digit_blank[i] = upper_zero;
        end
    end
`else
    assign digit_blank = '0;
`endif

    always_comb begin
        seg_next = SEG_BLANK;
        sel_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                sel_next[i] = 1'b0;
                if (overflow)            seg_next = SEG_DASH;
                else if (digit_blank[i]) seg_next = SEG_BLANK;
                else                     seg_next = seg_encode(disp_digits[i]);
            end
        end
    end

    // scan_idx names the digit driven at the next wrap, so digit 0 lights first.
    always_ff @(posedge clk100MHz or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
            scan_idx <= '0;
            LEDSEL   <= '1;
            LEDOUT   <= SEG_BLANK;
        end else if (tick_cnt == TICK_W'(TICK_DIV - 1)) begin
            tick_cnt <= '0;
            LEDSEL   <= sel_next;
            LEDOUT   <= seg_next;
            scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

endmodule
